// File: rtl/reg_write_arbiter.sv
// Two-writer arbiter for a bank of enable-gated register words.
// Ownership is round-robin on ties, bounded to MAX_BURST beats while the
// other writer waits, and unbounded while the other writer is idle.
// Write enables and write data are a combinational decode of the
// registered owner.
module reg_write_arbiter #(
  parameter int WIDTH     = 4,
  parameter int NREG      = 4,
  parameter int ADDR_W    = 2,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [WIDTH-1:0]  data_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  data_b,
  output logic              gnt_b,
  output logic [NREG-1:0]   wr_en,
  output logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              addr_err
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              last_b_reg, last_b_next;   // 1: B was the last owner
  logic [CNT_W-1:0]  burst_cnt_reg, burst_cnt_next;
  logic              addr_err_reg;

  logic              beat;       // owner is requesting this cycle
  logic              beat_ok;    // beat with an in-range address
  logic [ADDR_W-1:0] beat_addr;
  logic [WIDTH-1:0]  beat_data;

  // State register: owner, tie-break history, burst count and error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      last_b_reg    <= 1'b1;
      burst_cnt_reg <= '0;
      addr_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      last_b_reg    <= last_b_next;
      burst_cnt_reg <= burst_cnt_next;
      addr_err_reg  <= beat && !beat_ok;
    end
  end

  // Next-state logic: tie-break in IDLE, release or burst-limit handover when owning
  always_comb begin
    state_next     = state_reg;
    last_b_next    = last_b_reg;
    burst_cnt_next = burst_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        burst_cnt_next = '0;
        if (req_a && (!req_b || last_b_reg)) state_next = OWN_A;
        else if (req_b)                      state_next = OWN_B;
      end
      OWN_A: begin
        if (!req_a) begin
          state_next     = req_b ? OWN_B : IDLE;
          last_b_next    = 1'b0;
          burst_cnt_next = '0;
        end else if (req_b && burst_cnt_reg == CNT_MAX) begin
          state_next     = OWN_B;
          last_b_next    = 1'b0;
          burst_cnt_next = '0;
        end else if (burst_cnt_reg != CNT_MAX) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
        end
      end
      OWN_B: begin
        if (!req_b) begin
          state_next     = req_a ? OWN_A : IDLE;
          last_b_next    = 1'b1;
          burst_cnt_next = '0;
        end else if (req_a && burst_cnt_reg == CNT_MAX) begin
          state_next     = OWN_A;
          last_b_next    = 1'b1;
          burst_cnt_next = '0;
        end else if (burst_cnt_reg != CNT_MAX) begin
          burst_cnt_next = burst_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: select the owner's beat; reset suppresses any pending write
  always_comb begin
    beat      = 1'b0;
    beat_addr = '0;
    beat_data = '0;
    if (!reset) begin
      unique case (state_reg)
        OWN_A: begin
          beat      = req_a;
          beat_addr = addr_a;
          beat_data = data_a;
        end
        OWN_B: begin
          beat      = req_b;
          beat_addr = addr_b;
          beat_data = data_b;
        end
        default: ;
      endcase
    end
    beat_ok = beat && ({1'b0, beat_addr} < (ADDR_W + 1)'(NREG));
    wr_data = beat_ok ? beat_data : '0;
  end

  // One-hot word enables, one comparator per word
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_wr_en
      assign wr_en[gi] = beat_ok && (beat_addr == ADDR_W'(gi));
    end
  endgenerate

  assign gnt_a    = (state_reg == OWN_A);
  assign gnt_b    = (state_reg == OWN_B);
  assign busy     = (state_reg != IDLE);
  assign addr_err = addr_err_reg;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: a default 4-word instance and a
// 3-word instance for the out-of-range address case.
module tb_reg_write_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b;
  logic [1:0] addr_a, addr_b;
  logic [3:0] data_a, data_b;
  logic       gnt_a, gnt_b, busy, addr_err;
  logic [3:0] wr_en;
  logic [3:0] wr_data;

  logic       r3_req_a, r3_req_b;
  logic [1:0] r3_addr_a, r3_addr_b;
  logic [3:0] r3_data_a, r3_data_b;
  logic       r3_gnt_a, r3_gnt_b, r3_busy, r3_addr_err;
  logic [2:0] r3_wr_en;
  logic [3:0] r3_wr_data;

  logic [3:0] bank [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_write_arbiter #(.WIDTH(4), .NREG(4), .ADDR_W(2), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .gnt_a(gnt_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .gnt_b(gnt_b),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .addr_err(addr_err)
  );

  reg_write_arbiter #(.WIDTH(4), .NREG(3), .ADDR_W(2), .MAX_BURST(4)) dut3 (
    .clk(clk), .reset(reset),
    .req_a(r3_req_a), .addr_a(r3_addr_a), .data_a(r3_data_a), .gnt_a(r3_gnt_a),
    .req_b(r3_req_b), .addr_b(r3_addr_b), .data_b(r3_data_b), .gnt_b(r3_gnt_b),
    .wr_en(r3_wr_en), .wr_data(r3_wr_data), .busy(r3_busy), .addr_err(r3_addr_err)
  );

  // Register bank fed by the arbiter's enables
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wr_en[i]) bank[i] <= wr_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1;
    req_a = 0; req_b = 0; addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
    r3_req_a = 0; r3_req_b = 0; r3_addr_a = 0; r3_addr_b = 0; r3_data_a = 0; r3_data_b = 0;

    // Reset state
    tick();
    tick();
    chk("rst_gnt_a", 32'(gnt_a), 0);
    chk("rst_gnt_b", 32'(gnt_b), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_addr_err", 32'(addr_err), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_cnt", 32'(dut.burst_cnt_reg), 0);
    reset = 1'b0;

    // Single writer A: addr 2, data A, two beats
    req_a = 1; addr_a = 2'd2; data_a = 4'hA;
    settle();
    chk("t1_idle_gnt", 32'(gnt_a), 0);
    chk("t1_idle_wren", 32'(wr_en), 0);
    tick();
    chk("t1_gnt_a", 32'(gnt_a), 1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_wr_en1", 32'(wr_en), 32'h4);
    chk("t1_wr_data1", 32'(wr_data), 32'hA);
    tick();
    chk("t1_wr_en2", 32'(wr_en), 32'h4);
    chk("t1_wr_data2", 32'(wr_data), 32'hA);
    tick();
    req_a = 0;
    settle();
    chk("t1_nobeat", 32'(wr_en), 0);
    chk("t1_word2", 32'(bank[2]), 32'hA);
    tick();
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_idle_gnt_a", 32'(gnt_a), 0);

    // Tie from reset goes to A, then zero-gap handover to B
    reset = 1;
    tick();
    reset = 0;
    req_a = 1; addr_a = 2'd0; data_a = 4'h1;
    req_b = 1; addr_b = 2'd1; data_b = 4'h2;
    tick();
    chk("t2_gnt_a", 32'(gnt_a), 1);
    chk("t2_gnt_b", 32'(gnt_b), 0);
    chk("t2_wr_en", 32'(wr_en), 32'h1);
    tick();
    req_a = 0;
    settle();
    chk("t2_release", 32'(wr_en), 0);
    tick();
    chk("t2_ho_gnt_b", 32'(gnt_b), 1);
    chk("t2_ho_gnt_a", 32'(gnt_a), 0);
    chk("t2_ho_busy", 32'(busy), 1);
    chk("t2_ho_wr_en", 32'(wr_en), 32'h2);
    chk("t2_ho_data", 32'(wr_data), 32'h2);
    // B releases to A, then A releases to IDLE (last=A)
    req_b = 0; req_a = 1; addr_a = 2'd3; data_a = 4'h3;
    tick();
    chk("t2_back_a", 32'(gnt_a), 1);
    chk("t2_back_wren", 32'(wr_en), 32'h8);
    req_a = 0;
    tick();
    chk("t2_idle", 32'(busy), 0);
    // Next tie is won by B
    req_a = 1; req_b = 1;
    tick();
    chk("t2_tie_gnt_b", 32'(gnt_b), 1);
    chk("t2_tie_gnt_a", 32'(gnt_a), 0);
    chk("t2_tie_wren", 32'(wr_en), 32'h2);
    req_a = 0; req_b = 0;
    tick();
    chk("t2_end_busy", 32'(busy), 0);

    // Both held: bursts of 4 alternate (last=B, so A first)
    addr_a = 2'd0; data_a = 4'h5; addr_b = 2'd1; data_b = 4'h6;
    req_a = 1; req_b = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i < 4 || i >= 8)
        chk("t3_burst", {28'd0, gnt_a, gnt_b, wr_en[1:0]}, {28'd0, 4'b1001});
      else
        chk("t3_burst", {28'd0, gnt_a, gnt_b, wr_en[1:0]}, {28'd0, 4'b0110});
      chk("t3_excl", 32'(gnt_a & gnt_b), 0);
    end
    req_a = 0; req_b = 0;
    tick();
    chk("t3_end_busy", 32'(busy), 0);

    // A alone for 10 beats: no preemption, counter saturates
    req_a = 1; addr_a = 2'd1; data_a = 4'h7;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_beat", {29'd0, gnt_a, busy, wr_en[1]}, 32'h7);
    end
    chk("t4_cnt_sat", 32'(dut.burst_cnt_reg), 3);
    req_a = 0;
    settle();
    chk("t4_last_busy", 32'(busy), 1);
    tick();
    chk("t4_busy_drop", 32'(busy), 0);

    // NREG=3: address 3 is out of range
    r3_req_a = 1; r3_addr_a = 2'd3; r3_data_a = 4'h7;
    tick();
    chk("t5_gnt", 32'(r3_gnt_a), 1);
    chk("t5_oor_wren", 32'(r3_wr_en), 0);
    chk("t5_err_early", 32'(r3_addr_err), 0);
    tick();
    chk("t5_err_pulse", 32'(r3_addr_err), 1);
    r3_addr_a = 2'd1; r3_data_a = 4'h6;
    settle();
    chk("t5_ok_wren", 32'(r3_wr_en), 32'h2);
    chk("t5_ok_data", 32'(r3_wr_data), 32'h6);
    tick();
    chk("t5_err_clear", 32'(r3_addr_err), 0);
    r3_req_a = 0;
    tick();
    chk("t5_idle", 32'(r3_busy), 0);

    // Reset during the second beat of a B burst
    req_b = 1; addr_b = 2'd2; data_b = 4'h9;
    tick();
    chk("t6_beat1", 32'(wr_en), 32'h4);
    tick();
    data_b = 4'hC;
    reset = 1;
    settle();
    chk("t6_rst_wren", 32'(wr_en), 0);
    tick();
    reset = 0;
    settle();
    chk("t6_gnt_b", 32'(gnt_b), 0);
    chk("t6_wr_en", 32'(wr_en), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_cnt", 32'(dut.burst_cnt_reg), 0);
    chk("t6_word2", 32'(bank[2]), 32'h9);
    req_a = 1; addr_a = 2'd0; data_a = 4'h1;
    tick();
    chk("t6_tie_a", 32'(gnt_a), 1);
    chk("t6_tie_b", 32'(gnt_b), 0);
    req_a = 0; req_b = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
